// File: rtl/boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding and
// stream framing constants.
package boot_loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HDR_HI = 3'd1;
  localparam logic [2:0] ST_HDR_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    HDR_HI = ST_HDR_HI,
    HDR_LO = ST_HDR_LO,
    DATA   = ST_DATA,
    WRITE  = ST_WRITE,
    DONE   = ST_DONE,
    ERROR  = ST_ERROR
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// Assembles big-endian 32-bit words from a byte stream: 2-bit byte counter plus
// a left-shift register, MSB arrives first.
module byte_packer
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);

  logic [1:0]  r_cnt;
  logic [31:0] r_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 2'd0;
      r_shift <= 32'd0;
    end else if (clear) begin
      r_cnt   <= 2'd0;
      r_shift <= 32'd0;
    end else if (shift_en) begin
      r_shift <= {r_shift[23:0], byte_in};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  assign word_out  = r_shift;
  // High while the next accepted byte is the last one of the current word.
  assign word_full = (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot-time loader: parses a counted byte stream, writes instruction words into
// instruction memory and holds the CPU in reset until the image is complete.
module imem_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  localparam int unsigned IDX_W   = $clog2(DEPTH) + 1;
  localparam logic [16:0] L_DEPTH = 17'(DEPTH);

  state_t            r_state;
  logic [15:0]       r_count;
  logic [IDX_W-1:0]  r_index;
  logic [31:0]       r_addr;
  logic              r_byte_ready;
  logic              r_we;
  logic              r_cpu_rst;
  logic              r_done;
  logic              r_error;

  logic              w_accept;
  logic              w_restart;
  logic              w_shift_en;
  logic              w_word_full;
  logic [15:0]       w_hdr_count;
  logic [IDX_W-1:0]  w_index_nxt;
  logic [31:0]       w_word;

  assign w_accept    = byte_valid & r_byte_ready;
  assign w_restart   = start & ((r_state == IDLE) | (r_state == DONE) | (r_state == ERROR));
  assign w_shift_en  = w_accept & (r_state == DATA);
  assign w_hdr_count = {r_count[15:8], byte_data};
  assign w_index_nxt = r_index + 1'b1;

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_restart),
    .shift_en  (w_shift_en),
    .byte_in   (byte_data),
    .word_out  (w_word),
    .word_full (w_word_full)
  );

  // Outputs are registered alongside the state so each one reflects the state
  // entered on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_count      <= 16'd0;
      r_index      <= '0;
      r_addr       <= BASE_ADDR;
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_cpu_rst    <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            r_state      <= HDR_HI;
            r_count      <= 16'd0;
            r_index      <= '0;
            r_addr       <= BASE_ADDR;
            r_byte_ready <= 1'b1;
            r_cpu_rst    <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
          end
        end
        HDR_HI: begin
          if (w_accept) begin
            r_count[15:8] <= byte_data;
            r_state       <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (w_accept) begin
            r_count[7:0] <= byte_data;
            if (w_hdr_count == 16'd0) begin
              r_state      <= DONE;
              r_byte_ready <= 1'b0;
              r_cpu_rst    <= 1'b0;
              r_done       <= 1'b1;
            end else if ({1'b0, w_hdr_count} > L_DEPTH) begin
              r_state      <= ERROR;
              r_byte_ready <= 1'b0;
              r_error      <= 1'b1;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_accept && w_word_full) begin
            r_state      <= WRITE;
            r_byte_ready <= 1'b0;
            r_we         <= 1'b1;
          end
        end
        WRITE: begin
          r_index <= w_index_nxt;
          r_addr  <= r_addr + BYTES_PER_WORD;
          if (16'(w_index_nxt) == r_count) begin
            r_state   <= DONE;
            r_cpu_rst <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_state      <= DATA;
            r_byte_ready <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_byte_ready <= 1'b0;
          r_cpu_rst    <= 1'b1;
          r_done       <= 1'b0;
          r_error      <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = w_word;
  assign cpu_rst    = r_cpu_rst;
  assign done       = r_done;
  assign error      = r_error;

endmodule
